// File: rtl/shear_sort_ctrl.sv
// Sequencer for a ROW x COL shear-sort mesh: drives load, then alternating snake-row and
// column odd-even compare-exchange passes, ending with a row-only pass and a done pulse.
module shear_sort_ctrl #(
    parameter int unsigned ROW = 8,
    parameter int unsigned COL = 8,
    localparam int unsigned PHASES = $clog2(ROW) + 1,
    localparam int unsigned MAXD = (ROW > COL) ? ROW : COL,
    localparam int unsigned SW = $clog2(MAXD),
    localparam int unsigned PW = $clog2(PHASES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          hold_i,
    input  logic          abort_i,
    output logic          load_o,
    output logic          cmp_en_o,
    output logic          cmp_dim_o,
    output logic          cmp_odd_o,
    output logic [PW-1:0] phase_idx_o,
    output logic [SW-1:0] step_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [SW-1:0] RowLast   = SW'(ROW - 1);
    localparam logic [SW-1:0] ColLast   = SW'(COL - 1);
    localparam logic [PW-1:0] PhaseLast = PW'(PHASES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StRow, StCol, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [SW-1:0] step_q, step_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            phase_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        step_d    = step_q;
        load_o    = 1'b0;
        cmp_en_o  = 1'b0;
        cmp_dim_o = 1'b0;
        cmp_odd_o = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                step_d  = '0;
                if (start_i && !abort_i) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                load_o = !hold_i;
                if (!hold_i) begin
                    state_d = StRow;
                    phase_d = '0;
                    step_d  = '0;
                end
            end
            StRow: begin
                cmp_en_o  = !hold_i;
                cmp_odd_o = step_q[0];
                if (!hold_i) begin
                    if (step_q == ColLast) begin
                        step_d  = '0;
                        state_d = (phase_q == PhaseLast) ? StDone : StCol;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            StCol: begin
                cmp_en_o  = !hold_i;
                cmp_dim_o = 1'b1;
                cmp_odd_o = step_q[0];
                if (!hold_i) begin
                    if (step_q == RowLast) begin
                        step_d  = '0;
                        phase_d = phase_q + PW'(1);
                        state_d = StRow;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            StDone: begin
                // An aborted finish must not report completion.
                done_o = !hold_i && !abort_i;
                if (!hold_i) begin
                    state_d = StIdle;
                    phase_d = '0;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_i && state_q != StIdle) begin
            state_d = StIdle;
            phase_d = '0;
            step_d  = '0;
        end
    end

    assign phase_idx_o = phase_q;
    assign step_idx_o  = step_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_shear_sort_ctrl.sv
// Scoreboard bench: stimulus pushes expected strobe events, negedge monitors pop and compare.
module tb_shear_sort_ctrl;

    typedef struct {
        int cyc;
        int kind;  // 0 load, 1 compare step, 2 done, 9 several strobes at once
        int dim;
        int odd;
        int ph;
        int st;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   errors = 0;

    logic       start_a, hold_a, abort_a;
    logic       load_a, cmp_a, dim_a, odd_a, busy_a, done_a;
    logic [1:0] phase_a;
    logic [2:0] step_a;

    logic       start_b, hold_b, abort_b;
    logic       load_b, cmp_b, dim_b, odd_b, busy_b, done_b;
    logic [1:0] phase_b;
    logic [2:0] step_b;

    ev_t qa[$];
    ev_t qb[$];
    ev_t act_a, exp_a, act_b, exp_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shear_sort_ctrl #(.ROW(8), .COL(8)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .hold_i(hold_a), .abort_i(abort_a),
        .load_o(load_a), .cmp_en_o(cmp_a), .cmp_dim_o(dim_a), .cmp_odd_o(odd_a),
        .phase_idx_o(phase_a), .step_idx_o(step_a), .busy_o(busy_a), .done_o(done_a)
    );

    shear_sort_ctrl #(.ROW(4), .COL(6)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .hold_i(hold_b), .abort_i(abort_b),
        .load_o(load_b), .cmp_en_o(cmp_b), .cmp_dim_o(dim_b), .cmp_odd_o(odd_b),
        .phase_idx_o(phase_b), .step_idx_o(step_b), .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input string nm, input ev_t e, input ev_t a);
        bit bad;
        bad = (e.cyc != a.cyc) || (e.kind != a.kind) || (e.dim != a.dim) || (e.odd != a.odd) ||
              (e.kind != 2 && (e.ph != a.ph || e.st != a.st));
        tests++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got cyc=%0d kind=%0d dim=%0d odd=%0d ph=%0d st=%0d, expected cyc=%0d kind=%0d dim=%0d odd=%0d ph=%0d st=%0d",
                     nm, a.cyc, a.kind, a.dim, a.odd, a.ph, a.st,
                     e.cyc, e.kind, e.dim, e.odd, e.ph, e.st);
        end
    endtask

    function automatic ev_t mk(input int c, input int k, input int d, input int o,
                               input int p, input int s);
        ev_t e;
        e.cyc = c; e.kind = k; e.dim = d; e.odd = o; e.ph = p; e.st = s;
        return e;
    endfunction

    task automatic push(input int dut, input ev_t e);
        if (dut == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    // Expected strobes of one sort: load at L, up to ncmp steps, optional done at L+done_off.
    task automatic push_run(input int dut, input int L, input int rows, input int cols,
                            input int ph, input int ncmp, input int hold_idx,
                            input int hold_len, input int done_off);
        int i;
        int c;
        i = 0;
        push(dut, mk(L, 0, 0, 0, 0, 0));
        for (int p = 0; p < ph; p++) begin
            for (int s = 0; s < cols; s++) begin
                c = L + 1 + i + ((hold_idx >= 0 && i >= hold_idx) ? hold_len : 0);
                if (i < ncmp) push(dut, mk(c, 1, 0, s % 2, p, s));
                i++;
            end
            if (p < ph - 1) begin
                for (int s = 0; s < rows; s++) begin
                    c = L + 1 + i + ((hold_idx >= 0 && i >= hold_idx) ? hold_len : 0);
                    if (i < ncmp) push(dut, mk(c, 1, 1, s % 2, p, s));
                    i++;
                end
            end
        end
        if (done_off >= 0) push(dut, mk(L + done_off, 2, 0, 0, 0, 0));
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (load_a || cmp_a || done_a) begin
            act_a = mk(cyc, done_a ? 2 : (load_a ? 0 : 1), int'(dim_a), int'(odd_a),
                       int'(phase_a), int'(step_a));
            if (int'(load_a) + int'(cmp_a) + int'(done_a) > 1) act_a.kind = 9;
            if (qa.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL dut8x8 unexpected strobe: got kind=%0d at cycle %0d, expected none",
                         act_a.kind, cyc);
            end else begin
                exp_a = qa.pop_front();
                check_ev("dut8x8 event", exp_a, act_a);
            end
        end
    end

    always @(negedge clk) begin
        if (load_b || cmp_b || done_b) begin
            act_b = mk(cyc, done_b ? 2 : (load_b ? 0 : 1), int'(dim_b), int'(odd_b),
                       int'(phase_b), int'(step_b));
            if (int'(load_b) + int'(cmp_b) + int'(done_b) > 1) act_b.kind = 9;
            if (qb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL dut4x6 unexpected strobe: got kind=%0d at cycle %0d, expected none",
                         act_b.kind, cyc);
            end else begin
                exp_b = qb.pop_front();
                check_ev("dut4x6 event", exp_b, act_b);
            end
        end
    end

    task automatic start_a_pulse(output int L);
        start_a = 1'b1;
        L = cyc + 1;
        wait_cyc(L);
        start_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int L;
        int L2;
        rst_n = 1'b0;
        start_a = 0; hold_a = 0; abort_a = 0;
        start_b = 0; hold_b = 0; abort_b = 0;
        #3;
        chk("reset busy", int'(busy_a), 0);
        chk("reset load", int'(load_a), 0);
        chk("reset cmp_en", int'(cmp_a), 0);
        chk("reset done", int'(done_a), 0);
        chk("reset phase", int'(phase_a), 0);
        chk("reset step", int'(step_a), 0);
        #19 rst_n = 1'b1;
        wait_cyc(4);
        @(negedge clk);
        chk("idle busy", int'(busy_a), 0);
        chk("idle dim/odd", int'({dim_a, odd_a}), 0);

        // Plain 8x8 sort
        wait_cyc(5);
        start_a_pulse(L);
        push_run(0, L, 8, 8, 4, 56, -1, 0, 57);
        @(negedge clk);
        chk("run busy at load", int'(busy_a), 1);
        wait_cyc(L + 57);
        @(negedge clk);
        chk("busy at done", int'(busy_a), 1);
        wait_cyc(L + 58);
        @(negedge clk);
        chk("busy after done", int'(busy_a), 0);
        chk("idle step after done", int'(step_a), 0);

        // Hold for 5 cycles at row step 3 of phase 1
        wait_cyc(cyc + 2);
        start_a_pulse(L);
        push_run(0, L, 8, 8, 4, 56, 19, 5, 62);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(L + 20 + k);
            if (k == 0) hold_a = 1'b1;
            @(negedge clk);
            chk("hold cmp_en low", int'(cmp_a), 0);
            chk("hold step frozen", int'(step_a), 3);
            chk("hold phase frozen", int'(phase_a), 1);
        end
        wait_cyc(L + 25);
        hold_a = 1'b0;
        wait_cyc(L + 63);
        @(negedge clk);
        chk("busy after held run", int'(busy_a), 0);

        // Abort during column step 2 of phase 2, restart two cycles later
        wait_cyc(cyc + 2);
        start_a_pulse(L);
        push_run(0, L, 8, 8, 4, 43, -1, 0, -1);
        wait_cyc(L + 43);
        abort_a = 1'b1;
        wait_cyc(L + 44);
        abort_a = 1'b0;
        @(negedge clk);
        chk("busy after abort", int'(busy_a), 0);
        wait_cyc(L + 45);
        start_a_pulse(L2);
        chk("restart load cycle", L2, L + 46);
        push_run(0, L2, 8, 8, 4, 56, -1, 0, 57);
        wait_cyc(L2 + 58);
        @(negedge clk);
        chk("busy after restart", int'(busy_a), 0);

        // Asynchronous reset at step 5 of phase 0
        wait_cyc(cyc + 2);
        start_a_pulse(L);
        push_run(0, L, 8, 8, 4, 5, -1, 0, -1);
        wait_cyc(L + 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst cmp_en", int'(cmp_a), 0);
        chk("async rst busy", int'(busy_a), 0);
        chk("async rst step", int'(step_a), 0);
        chk("async rst phase", int'(phase_a), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_cyc(cyc + 1);
        @(negedge clk);
        chk("busy after rst release", int'(busy_a), 0);
        wait_cyc(cyc + 1);
        start_a_pulse(L);
        push_run(0, L, 8, 8, 4, 56, -1, 0, 57);
        wait_cyc(L + 58);
        @(negedge clk);
        chk("busy after post-reset run", int'(busy_a), 0);

        // 4x6 mesh with extra starts while busy and in the done cycle
        wait_cyc(cyc + 2);
        start_b = 1'b1;
        L = cyc + 1;
        wait_cyc(L);
        start_b = 1'b0;
        push_run(1, L, 4, 6, 3, 26, -1, 0, 27);
        for (int k = 0; k < 3; k++) begin
            wait_cyc(L + ((k == 0) ? 5 : ((k == 1) ? 10 : 27)));
            start_b = 1'b1;
            @(negedge clk);
            chk("4x6 busy during extra start", int'(busy_b), 1);
            wait_cyc(cyc + 1);
            start_b = 1'b0;
        end
        @(negedge clk);
        chk("4x6 busy after done", int'(busy_b), 0);
        wait_cyc(L + 31);
        @(negedge clk);
        chk("4x6 stays idle", int'(busy_b), 0);

        for (int k = 0; k < 50 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
        chk("dut8x8 queue drained", qa.size(), 0);
        chk("dut4x6 queue drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/shear_sort_ctrl.md
SHEAR_SORT_CTRL -- requirements
Module: shear_sort_ctrl

Interface
REQ-001 Parameter ROW, default 8, mesh row count; legal range ROW>=2.
REQ-002 Parameter COL, default 8, mesh column count; legal range COL>=2.
REQ-003 Derived constant PHASES = $clog2(ROW)+1; SW = $clog2(max(ROW,COL)); PW = $clog2(PHASES).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a sort of the values currently on the datapath load bus.
REQ-007 hold  input  1  stall; freezes sequencing while high.
REQ-008 abort  input  1  synchronous cancel of a running sort.
REQ-009 load  output  1  one-cycle strobe: datapath captures init_values.
REQ-010 cmp_en  output  1  datapath performs one compare-exchange step this cycle.
REQ-011 cmp_dim  output  1  0 = row step (snake order), 1 = column step.
REQ-012 cmp_odd  output  1  0 = even pairs (0-1, 2-3, ...), 1 = odd pairs (1-2, 3-4, ...).
REQ-013 phase_idx  output  PW  current shear-sort phase, 0..PHASES-1.
REQ-014 step_idx  output  SW  current step within the row or column pass.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, ROW, COL and DONE.
REQ-018 IDLE: start=1 and abort=0 -> LOAD; otherwise stay; hold is ignored.
REQ-019 LOAD: load=1 for exactly one cycle -> ROW; phase_idx=0, step_idx=0.
REQ-020 ROW: cmp_en=1, cmp_dim=0, cmp_odd=step_idx[0]; COL steps, 0..COL-1.
REQ-021 ROW at step COL-1: if phase_idx==PHASES-1 -> DONE, else -> COL with step_idx=0.
REQ-022 COL: cmp_en=1, cmp_dim=1, cmp_odd=step_idx[0]; ROW steps, 0..ROW-1.
REQ-023 COL at step ROW-1: -> ROW, phase_idx+1, step_idx=0.
REQ-024 DONE: done=1 for one cycle -> IDLE unconditionally; start in this cycle is ignored.
REQ-025 hold=1 in LOAD/ROW/COL/DONE: state, phase_idx and step_idx are frozen; load, cmp_en and done are forced to 0. The frozen action repeats once hold falls.
REQ-026 abort=1 in any non-IDLE state: -> IDLE next edge with no done pulse; abort has priority over hold.
REQ-027 start while busy=1 SHALL be ignored with no effect on sequencing.
REQ-028 Latency without hold: load in cycle L; cmp_en high in cycles L+1..L+PHASES*COL+(PHASES-1)*ROW; done in the following cycle.
REQ-029 8x8 default: 32 row steps plus 24 column steps give 56 cmp_en cycles, and done is asserted at L+57.
REQ-030 In IDLE, cmp_dim, cmp_odd, phase_idx and step_idx SHALL be 0.
REQ-031 Counters SHALL never wrap: step_idx never exceeds its pass length minus 1, and phase_idx never exceeds PHASES-1.

Reset
REQ-032 rst=0 SHALL immediately force IDLE and all outputs and counters to 0, including mid-sort.
REQ-033 After rst rises, the block SHALL act on no start until the first rising clk edge.

Verification
REQ-034 Reset then start pulse, default 8x8, no hold -> load at L, 56 contiguous cmp_en cycles, done at L+57, busy low at L+58.
REQ-035 Check the step pattern for 8x8 -> cmp_dim/cmp_odd/phase_idx follow 8 row steps (odd 0,1,0,1...), then 8 column steps, repeated; phase 3 is row-only.
REQ-036 hold=1 for 5 cycles at row step 3 of phase 1 -> cmp_en low for 5 cycles, step_idx stays 3, done at L+62.
REQ-037 abort during a COL step of phase 2, then start 2 cycles later -> no done pulse; a fresh load occurs and the full 58-cycle sequence restarts.
REQ-038 rst=0 during step 5 of phase 0, asynchronous to clk -> all outputs 0 before the next edge; start after reset gives normal completion.
REQ-039 ROW=4, COL=6, start repeated during busy and in the DONE cycle -> PHASES=3, 18+8=26 cmp_en cycles, done at L+27, extra starts have no effect.
